// File: rtl/eth_payload_writer.sv
// eth_payload_writer: streams payload bytes into the Ethernet TX frame buffer
// (addr/data -> strobe -> release per byte), then requests a transmit and
// follows tx_busy until the frame has gone out.
// Optional build macro ETH_PAYLOAD_WRITER_SEQ_EN: appends a 16-bit frame
// sequence number after the payload (seq[7:0] at BASE_ADDR+LEN+1,
// seq[15:8] at BASE_ADDR+LEN).
module eth_payload_writer #(
    parameter int unsigned BASE_ADDR    = 'h38,
    parameter int unsigned LEN          = 4,
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned BUSY_TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] eth_w_addr,
    output logic [7:0]        eth_w_data,
    output logic              eth_w_en,
    output logic              start,
    input  logic              tx_busy,
    output logic              frame_done,
    output logic              err
);

    localparam int TO_W = $clog2(BUSY_TIMEOUT + 1);
    // err must appear BUSY_TIMEOUT enabled cycles after the start cycle; the
    // START cycle and the err cycle itself account for two of them.
    localparam int unsigned TO_LAST_I = (BUSY_TIMEOUT >= 2) ? BUSY_TIMEOUT - 2 : 0;
    localparam logic [TO_W-1:0] TO_LAST = TO_LAST_I[TO_W-1:0];
    // Highest payload address; the first byte of the frame lands here.
    localparam int unsigned TOP_I = BASE_ADDR + LEN - 1;
    localparam logic [ADDR_W-1:0] TOP = TOP_I[ADDR_W-1:0];
    localparam int unsigned LAST_I = LEN - 1;
    localparam logic [7:0] LAST = LAST_I[7:0];

    typedef enum logic [3:0] {
        S_IDLE,
        S_COLLECT,
        S_SEQ_PREP,
        S_LOAD,
        S_STROBE,
        S_RELEASE,
        S_START,
        S_WAIT_RISE,
        S_WAIT_FALL
    } state_t;

    state_t          state;
    logic [7:0]      k;
    logic [TO_W-1:0] to_cnt;
    logic            accept;

`ifdef ETH_PAYLOAD_WRITER_SEQ_EN
    logic [15:0] seq;
    logic [1:0]  extra;
`endif

    // Handshake: IDLE only accepts once the previous frame has left the TX
    // block; reset forces ready low immediately.
    assign in_ready = rst_n && (((state == S_IDLE) && !tx_busy) || (state == S_COLLECT));
    assign accept   = in_valid && in_ready;

    // Frame sequencer with registered buffer-port and pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            k          <= '0;
            to_cnt     <= '0;
            eth_w_addr <= '0;
            eth_w_data <= '0;
            eth_w_en   <= 1'b0;
            start      <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
`ifdef ETH_PAYLOAD_WRITER_SEQ_EN
            seq        <= '0;
            extra      <= '0;
`endif
        end else if (clk_en) begin
            start      <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            case (state)
                S_IDLE, S_COLLECT: begin
                    if (accept) begin
                        eth_w_addr <= TOP - ADDR_W'(k);
                        eth_w_data <= in_data;
                        state      <= S_LOAD;
                    end
                end
`ifdef ETH_PAYLOAD_WRITER_SEQ_EN
                S_SEQ_PREP: begin
                    if (extra == 2'd1) begin
                        eth_w_addr <= TOP + ADDR_W'(2);
                        eth_w_data <= seq[7:0];
                    end else begin
                        eth_w_addr <= TOP + ADDR_W'(1);
                        eth_w_data <= seq[15:8];
                    end
                    state <= S_LOAD;
                end
`endif
                S_LOAD: begin
                    eth_w_en <= 1'b1;
                    state    <= S_STROBE;
                end
                S_STROBE: begin
                    eth_w_en <= 1'b0;
                    state    <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (k != LAST) begin
                        k     <= k + 8'd1;
                        state <= S_COLLECT;
                    end
`ifdef ETH_PAYLOAD_WRITER_SEQ_EN
                    else if (extra != 2'd2) begin
                        extra <= extra + 2'd1;
                        state <= S_SEQ_PREP;
                    end
`endif
                    else begin
                        k     <= '0;
                        start <= 1'b1;
                        state <= S_START;
`ifdef ETH_PAYLOAD_WRITER_SEQ_EN
                        extra <= '0;
`endif
                    end
                end
                S_START: begin
                    to_cnt <= '0;
                    state  <= S_WAIT_RISE;
                end
                S_WAIT_RISE: begin
                    if (tx_busy) begin
                        state <= S_WAIT_FALL;
                    end else if (to_cnt == TO_LAST) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                S_WAIT_FALL: begin
                    if (!tx_busy) begin
                        frame_done <= 1'b1;
                        state      <= S_IDLE;
`ifdef ETH_PAYLOAD_WRITER_SEQ_EN
                        seq        <= seq + 16'd1;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
